// File: rtl/sar_pkg.sv
// Shared definitions for the SAR comparator/sample-and-hold stand-in.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CONVERT = 2'd2
  } state_t;

  localparam int SAR_WIDTH      = 8;
  localparam int ARM_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF    = 16;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit incrementer that sticks at 255 instead of wrapping; synchronous clear.
module sat_counter8 (
  input  logic       clk,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/sar_cmp_responder.sv
// Comparator + sample-and-hold stand-in for the SAR ADC controller: holds a
// digital sample, runs the SAR through reset/convert and checks its result.
module sar_cmp_responder
  import sar_pkg::*;
#(
  parameter int WIDTH      = SAR_WIDTH,
  parameter int ARM_CYCLES = ARM_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_value,
  output logic             sample_ready,
  output logic             sar_rst_n,
  input  logic [WIDTH-1:0] dac_code,
  input  logic             sar_done,
  output logic             cmp_out,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_code,
  output logic             result_match,
  output logic             result_timeout,
  output logic [7:0]       conv_count,
  output logic [7:0]       err_count,
  output state_t           debug_state
);

  localparam int TMR_MAX = (TIMEOUT > ARM_CYCLES) ? TIMEOUT : ARM_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t             state, state_next;
  logic [TMR_W-1:0]   tmr, tmr_next;
  logic [WIDTH-1:0]   held;
  logic               held_load;
  logic               exit_done, exit_tmo, exit_any, done_match;

  // Handshake: a sample transfers on a rising edge where sample_valid and
  // sample_ready are both high; the source keeps valid/value stable until then.
  assign sample_ready = (state == IDLE);
  assign cmp_out      = (state == CONVERT) && (held >= dac_code);
  assign debug_state  = state;

  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    held_load  = 1'b0;
    exit_done  = 1'b0;
    exit_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          state_next = ARM;
          tmr_next   = '0;
          held_load  = 1'b1;
        end
      end
      ARM: begin
        if (tmr == TMR_W'(ARM_CYCLES - 1)) begin
          state_next = CONVERT;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr + 1'b1;
        end
      end
      CONVERT: begin
        tmr_next = tmr + 1'b1;
        // Done takes priority over a timeout landing in the same cycle.
        if (sar_done) begin
          exit_done  = 1'b1;
          state_next = IDLE;
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          exit_tmo   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign exit_any   = exit_done || exit_tmo;
  assign done_match = exit_done && (dac_code == held);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      tmr            <= '0;
      held           <= '0;
      sar_rst_n      <= 1'b0;
      result_valid   <= 1'b0;
      result_code    <= '0;
      result_match   <= 1'b0;
      result_timeout <= 1'b0;
    end else begin
      state        <= state_next;
      tmr          <= tmr_next;
      sar_rst_n    <= (state_next == CONVERT);
      result_valid <= exit_any;
      if (held_load) begin
        held <= sample_value;
      end
      if (exit_any) begin
        result_code    <= dac_code;
        result_match   <= done_match;
        result_timeout <= exit_tmo;
      end
    end
  end

  sat_counter8 u_conv_count (
    .clk   (clk),
    .clear (rst),
    .inc   (exit_any),
    .count (conv_count)
  );

  sat_counter8 u_err_count (
    .clk   (clk),
    .clear (rst),
    .inc   (exit_any && !done_match),
    .count (err_count)
  );

endmodule

// File: tb/tb_sar_cmp_responder.sv
// Directed bench for sar_cmp_responder with a behavioural 8-bit SAR model.
module tb_sar_cmp_responder;
  import sar_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_value = 8'h00;
  logic       sample_ready;
  logic       sar_rst_n;
  logic [7:0] dac_code;
  logic       sar_done;
  logic       cmp_out;
  logic       result_valid;
  logic [7:0] result_code;
  logic       result_match;
  logic       result_timeout;
  logic [7:0] conv_count;
  logic [7:0] err_count;
  state_t     debug_state;

  int checks = 0;
  int errors = 0;

  // SAR model knobs
  logic done_stuck = 1'b0;
  logic force_bit0 = 1'b0;
  logic done_force = 1'b0;

  always #5 clk = ~clk;

  sar_cmp_responder dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid   (sample_valid),
    .sample_value   (sample_value),
    .sample_ready   (sample_ready),
    .sar_rst_n      (sar_rst_n),
    .dac_code       (dac_code),
    .sar_done       (sar_done),
    .cmp_out        (cmp_out),
    .result_valid   (result_valid),
    .result_code    (result_code),
    .result_match   (result_match),
    .result_timeout (result_timeout),
    .conv_count     (conv_count),
    .err_count      (err_count),
    .debug_state    (debug_state)
  );

  // Behavioural successive-approximation controller: MSB first, keep bit on cmp=1.
  logic [7:0] m_code = 8'h00;
  logic [7:0] m_tmp;
  int         m_idx = 7;
  logic       m_done = 1'b0;

  always @(posedge clk) begin
    if (!sar_rst_n) begin
      m_code <= 8'h80;
      m_idx  <= 7;
      m_done <= 1'b0;
    end else if (!m_done) begin
      m_tmp = m_code;
      if (!cmp_out) m_tmp[m_idx] = 1'b0;
      if (m_idx == 0) m_done <= 1'b1;
      else m_tmp[m_idx-1] = 1'b1;
      m_code <= m_tmp;
      m_idx  <= m_idx - 1;
    end
  end

  assign dac_code = m_code | {7'd0, force_bit0 & m_done};
  assign sar_done = (m_done & ~done_stuck) | done_force;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    done_stuck = 1'b0;
    force_bit0 = 1'b0;
    done_force = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers v, optionally keeps valid high with next_v while busy, and returns
  // at the negedge of the result cycle.
  task automatic convert(input logic [7:0] v, input bit keep, input logic [7:0] next_v,
                         output logic [7:0] code, output logic match, output logic tmo,
                         output int lows, output int conv_cycles, output int busy_ready,
                         output state_t st, output bit ok);
    int n;
    ok = 1'b0; lows = 0; conv_cycles = 0; busy_ready = 0;
    code = 8'h00; match = 1'b0; tmo = 1'b0; st = IDLE;
    sample_value = v;
    sample_valid = 1'b1;
    n = 0;
    while (!sample_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    if (keep) sample_value = next_v;
    else sample_valid = 1'b0;
    n = 0;
    while (!sar_rst_n && n < 100) begin
      if (sample_ready) busy_ready++;
      lows++;
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!result_valid && n < 100) begin
      if (sample_ready) busy_ready++;
      @(negedge clk);
      conv_cycles++;
      n++;
    end
    if (result_valid) begin
      ok = 1'b1;
      code = result_code;
      match = result_match;
      tmo = result_timeout;
      st = debug_state;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sar_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sar_rst_n got %b exp 0", sar_rst_n); end
    checks++; if (cmp_out !== 1'b0) begin errors++; $display("FAIL reset_cmp_out got %b exp 0", cmp_out); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_sample_ready got %b exp 1", sample_ready); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %b exp 0", result_valid); end
    checks++; if (result_match !== 1'b0) begin errors++; $display("FAIL reset_result_match got %b exp 0", result_match); end
    checks++; if (result_timeout !== 1'b0) begin errors++; $display("FAIL reset_result_timeout got %b exp 0", result_timeout); end
    checks++; if (result_code !== 8'h00) begin errors++; $display("FAIL reset_result_code got %h exp 00", result_code); end
    checks++; if (conv_count !== 8'd0) begin errors++; $display("FAIL reset_conv_count got %0d exp 0", conv_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    checks++; if (debug_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", debug_state); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] code; logic match, tmo; int lows, cyc, br; state_t st; bit ok;
    do_reset();
    convert(8'hA5, 1'b0, 8'h00, code, match, tmo, lows, cyc, br, st, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_result_seen got %b exp 1", ok); end
    checks++; if (lows != 2) begin errors++; $display("FAIL single_arm_low_cycles got %0d exp 2", lows); end
    checks++; if (code !== 8'hA5) begin errors++; $display("FAIL single_code got %h exp a5", code); end
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL single_match got %b exp 1", match); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL single_timeout got %b exp 0", tmo); end
    checks++; if (conv_count !== 8'd1) begin errors++; $display("FAIL single_conv_count got %0d exp 1", conv_count); end
    checks++; if (st !== IDLE) begin errors++; $display("FAIL single_state_at_result got %0d exp IDLE", st); end
    @(negedge clk);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b exp 0", result_valid); end
    checks++; if (result_code !== 8'hA5) begin errors++; $display("FAIL single_code_hold got %h exp a5", result_code); end
  endtask

  task automatic test_sweep();
    logic [7:0] code; logic match, tmo; int lows, cyc, br; state_t st; bit ok;
    int exp_cnt;
    do_reset();
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), 1'b0, 8'h00, code, match, tmo, lows, cyc, br, st, ok);
      checks++;
      if (!ok || code !== 8'(v) || match !== 1'b1) begin
        errors++;
        $display("FAIL sweep_result v=%h got code %h match %b ok %b exp code %h match 1", v[7:0], code, match, ok, v[7:0]);
      end
      exp_cnt = (v + 1 > 255) ? 255 : v + 1;
      checks++;
      if (conv_count !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL sweep_conv_count v=%h got %0d exp %0d", v[7:0], conv_count, exp_cnt);
      end
    end
    checks++; if (conv_count !== 8'd255) begin errors++; $display("FAIL sweep_saturate got %0d exp 255", conv_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL sweep_err_count got %0d exp 0", err_count); end
  endtask

  task automatic test_timeout();
    logic [7:0] code; logic match, tmo; int lows, cyc, br; state_t st; bit ok;
    do_reset();
    done_stuck = 1'b1;
    convert(8'h5A, 1'b0, 8'h00, code, match, tmo, lows, cyc, br, st, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL timeout_result_seen got %b exp 1", ok); end
    checks++; if (cyc != 16) begin errors++; $display("FAIL timeout_latency got %0d exp 16", cyc); end
    checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", tmo); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL timeout_match got %b exp 0", match); end
    checks++; if (code !== 8'h5A) begin errors++; $display("FAIL timeout_code got %h exp 5a", code); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_err_count got %0d exp 1", err_count); end
    done_stuck = 1'b0;
  endtask

  task automatic test_faulty();
    logic [7:0] code; logic match, tmo; int lows, cyc, br; state_t st; bit ok;
    do_reset();
    force_bit0 = 1'b1;
    convert(8'h40, 1'b0, 8'h00, code, match, tmo, lows, cyc, br, st, ok);
    checks++; if (code !== 8'h41) begin errors++; $display("FAIL faulty_code got %h exp 41", code); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL faulty_match got %b exp 0", match); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL faulty_timeout got %b exp 0", tmo); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL faulty_err_count got %0d exp 1", err_count); end
    force_bit0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] code; logic match, tmo; int lows, cyc, br; state_t st; bit ok;
    do_reset();
    convert(8'h33, 1'b1, 8'h99, code, match, tmo, lows, cyc, br, st, ok);
    checks++; if (code !== 8'h33 || match !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp 33/1", code, match); end
    checks++; if (br != 0) begin errors++; $display("FAIL b2b_ready_while_busy got %0d exp 0", br); end
    convert(8'h99, 1'b0, 8'h00, code, match, tmo, lows, cyc, br, st, ok);
    checks++; if (lows != 2) begin errors++; $display("FAIL b2b_arm_low_cycles got %0d exp 2", lows); end
    checks++; if (code !== 8'h99 || match !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b exp 99/1", code, match); end
    checks++; if (conv_count !== 8'd2) begin errors++; $display("FAIL b2b_conv_count got %0d exp 2", conv_count); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] code; logic match, tmo; int lows, cyc, br; state_t st; bit ok;
    int n; int pulses;
    do_reset();
    sample_value = 8'h33;
    sample_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!sar_rst_n && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++; if (debug_state !== CONVERT) begin errors++; $display("FAIL midrst_in_convert got %0d exp CONVERT", debug_state); end
    rst = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (debug_state !== IDLE) begin errors++; $display("FAIL midrst_state got %0d exp IDLE", debug_state); end
    checks++; if (sar_rst_n !== 1'b0) begin errors++; $display("FAIL midrst_sar_rst_n got %b exp 0", sar_rst_n); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (result_valid) pulses++;
      @(negedge clk);
    end
    done_force = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    done_force = 1'b0;
    @(negedge clk);
    if (result_valid) pulses++;
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_pulse got %0d exp 0", pulses); end
    checks++; if (conv_count !== 8'd0 || err_count !== 8'd0) begin errors++; $display("FAIL midrst_counters got %0d/%0d exp 0/0", conv_count, err_count); end
    checks++; if (debug_state !== IDLE) begin errors++; $display("FAIL midrst_spurious_done_state got %0d exp IDLE", debug_state); end
    convert(8'h99, 1'b0, 8'h00, code, match, tmo, lows, cyc, br, st, ok);
    checks++; if (code !== 8'h99 || match !== 1'b1 || tmo !== 1'b0) begin errors++; $display("FAIL midrst_next got %h/%b/%b exp 99/1/0", code, match, tmo); end
    checks++; if (conv_count !== 8'd1 || err_count !== 8'd0) begin errors++; $display("FAIL midrst_next_counters got %0d/%0d exp 1/0", conv_count, err_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_timeout();
    test_faulty();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
